mips32_imem_loader: RTL

Boot-time program loader for the MIPS32 pipeline: accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instruction words, and writes them into instruction memory starting at word address 0. Loading stops at the first HLT word (opcode 6'h3F, e.g. 32'hFC000000). The loader then raises `cpu_run`, which releases the processor core to start fetching. It is the writer side of the instruction-memory port the core reads from.

---
 rtl/mips32_imem_loader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mips32_imem_loader.sv
// Boot loader: packs a big-endian byte stream into imem words until HLT.
// Define IMEM_CHKSUM_EN to require a trailing zero-sum checksum byte.
module mips32_imem_loader #(
    parameter int WORDS  = 1024,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic              clk_1,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
`ifdef IMEM_CHKSUM_EN
        ,S_CHECK = 3'd5
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic              s_ready_q, s_ready_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef IMEM_CHKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    // Next-state, datapath and output decode; start overrides everything.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        wcnt_d     = wcnt_q;
`ifdef IMEM_CHKSUM_EN
        sum_d      = sum_q;
`endif
        if (start) begin
            state_d    = S_LOAD;
            byte_cnt_d = 2'd0;
            shift_d    = 32'h0;
            addr_d     = '0;
            wcnt_d     = '0;
`ifdef IMEM_CHKSUM_EN
            sum_d      = 8'h00;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (s_valid) begin
                        shift_d    = {shift_q[23:0], s_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_CHKSUM_EN
                        sum_d      = sum_q + s_data;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            state_d = S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    wcnt_d = wcnt_q + (ADDR_W + 1)'(1);
                    if (shift_q[31:26] == 6'h3F) begin
`ifdef IMEM_CHKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end else if (addr_q == LAST_ADDR) begin
                        state_d = S_ERR;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_LOAD;
                    end
                end
`ifdef IMEM_CHKSUM_EN
                S_CHECK: begin
                    if (s_valid) begin
                        if ((sum_q + s_data) == 8'h00) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
`endif
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        we_d      = (state_d == S_WRITE);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
`ifdef IMEM_CHKSUM_EN
        s_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
        busy_d    = (state_d == S_LOAD) || (state_d == S_WRITE) ||
                    (state_d == S_CHECK);
`else
        s_ready_d = (state_d == S_LOAD);
        busy_d    = (state_d == S_LOAD) || (state_d == S_WRITE);
`endif
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'h0;
            addr_q     <= '0;
            wcnt_q     <= '0;
            s_ready_q  <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_CHKSUM_EN
            sum_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            wcnt_q     <= wcnt_d;
            s_ready_q  <= s_ready_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef IMEM_CHKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign s_ready    = s_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = shift_q;
    assign cpu_run    = done_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = wcnt_q;

endmodule
